// File: rtl/cdc_fifo_push_credit_sender_if.sv
// Handshake bundle between producer, credit sender and the push side of the CDC FIFO.
// master = the credit sender, slave = the surrounding producer/FIFO environment.
interface cdc_fifo_push_credit_sender_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  push_valid;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  push_credit;

    modport master (
        input  in_valid,
        output in_ready,
        input  in_data,
        output push_valid,
        output push_data,
        input  push_credit
    );

    modport slave (
        output in_valid,
        input  in_ready,
        output in_data,
        input  push_valid,
        input  push_data,
        output push_credit
    );
endinterface

// File: rtl/cdc_fifo_push_credit_sender.sv
// Credit-based sender feeding the push side of the CDC flop-RAM FIFO.
// Holds one credit per free FIFO slot; spends one per push beat, re-absorbs returned credits.
module cdc_fifo_push_credit_sender #(
    parameter int DATA_WIDTH   = 8,
    parameter int MAX_CREDITS  = 17,
    parameter int CREDIT_WIDTH = 5
) (
    input  logic                          push_clk,
    input  logic                          push_rst_n,
    cdc_fifo_push_credit_sender_if.master bus,
    input  logic                          push_credit_stall,
    input  logic [CREDIT_WIDTH-1:0]       credit_initial_push,
    input  logic [CREDIT_WIDTH-1:0]       credit_withhold_push,
    output logic                          push_sender_in_reset,
    output logic [CREDIT_WIDTH-1:0]       credit_count_push,
    output logic [CREDIT_WIDTH-1:0]       credit_available_push,
    output logic                          credit_overflow
);

    if ((1 << CREDIT_WIDTH) <= MAX_CREDITS) begin : g_bad_cfg
        $error("CREDIT_WIDTH too narrow for MAX_CREDITS");
    end

    localparam logic [CREDIT_WIDTH-1:0] MAX_C = CREDIT_WIDTH'(MAX_CREDITS);
    localparam logic [CREDIT_WIDTH-1:0] ONE_C = CREDIT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CREDIT_WIDTH-1:0] count_q, count_d;
    logic                    overflow_q, overflow_d;
    logic                    in_reset_q, in_reset_d;
    logic                    push_valid_q, push_valid_d;
    logic [DATA_WIDTH-1:0]   push_data_q, push_data_d;
    logic [CREDIT_WIDTH-1:0] avail_s;
    logic                    in_ready_s;
    logic                    fire_s;

    function automatic logic [CREDIT_WIDTH-1:0] clamp_credits(input logic [CREDIT_WIDTH-1:0] v);
        if (v > MAX_C) begin
            clamp_credits = MAX_C;
        end else begin
            clamp_credits = v;
        end
    endfunction

    // Spendable credits and producer handshake
    always_comb begin
        avail_s = {CREDIT_WIDTH{1'b0}};
        if (count_q > credit_withhold_push) begin
            avail_s = count_q - credit_withhold_push;
        end else begin
            avail_s = {CREDIT_WIDTH{1'b0}};
        end
        in_ready_s = (state_q == ST_ACTIVE) && !push_credit_stall
                     && (avail_s != {CREDIT_WIDTH{1'b0}});
        fire_s     = bus.in_valid && in_ready_s;
    end

    // Next-state: sequencing, credit accounting and push beat
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        push_valid_d = fire_s;
        push_data_d  = push_data_q;

        if (fire_s) begin
            push_data_d = bus.in_data;
        end else begin
            push_data_d = push_data_q;
        end

        case (state_q)
            ST_RESET: begin
                state_d = ST_INIT;
                count_d = {CREDIT_WIDTH{1'b0}};
            end
            ST_INIT: begin
                state_d = ST_ACTIVE;
                count_d = clamp_credits(credit_initial_push);
            end
            ST_ACTIVE: begin
                state_d = ST_ACTIVE;
                // fire and return together leave the count untouched
                if (fire_s && !bus.push_credit) begin
                    count_d = count_q - ONE_C;
                end else if (!fire_s && bus.push_credit) begin
                    if (count_q >= MAX_C) begin
                        count_d    = MAX_C;
                        overflow_d = 1'b1;
                    end else begin
                        count_d = count_q + ONE_C;
                    end
                end else begin
                    count_d = count_q;
                end
            end
            default: begin
                state_d = ST_RESET;
                count_d = {CREDIT_WIDTH{1'b0}};
            end
        endcase

        in_reset_d = (state_d != ST_ACTIVE);
    end

    // State and output registers
    always_ff @(posedge push_clk or negedge push_rst_n) begin
        if (!push_rst_n) begin
            state_q      <= ST_RESET;
            count_q      <= {CREDIT_WIDTH{1'b0}};
            overflow_q   <= 1'b0;
            in_reset_q   <= 1'b1;
            push_valid_q <= 1'b0;
            push_data_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            in_reset_q   <= in_reset_d;
            push_valid_q <= push_valid_d;
            push_data_q  <= push_data_d;
        end
    end

    assign bus.in_ready           = in_ready_s;
    assign bus.push_valid         = push_valid_q;
    assign bus.push_data          = push_data_q;
    assign push_sender_in_reset   = in_reset_q;
    assign credit_count_push      = count_q;
    assign credit_available_push  = avail_s;
    assign credit_overflow        = overflow_q;

endmodule

// File: tb/tb_cdc_fifo_push_credit_sender.sv
// Directed bench for the push-side credit sender (MAX_CREDITS=17, CREDIT_WIDTH=5).
module tb_cdc_fifo_push_credit_sender;

    logic       clk;
    logic       rst_n;
    logic       stall;
    logic [4:0] init_c;
    logic [4:0] withhold;
    logic       in_reset;
    logic [4:0] count;
    logic [4:0] avail;
    logic       ovf;
    int         total;
    int         bad;

    cdc_fifo_push_credit_sender_if #(.DATA_WIDTH(8)) bus ();

    cdc_fifo_push_credit_sender #(
        .DATA_WIDTH  (8),
        .MAX_CREDITS (17),
        .CREDIT_WIDTH(5)
    ) dut (
        .push_clk             (clk),
        .push_rst_n           (rst_n),
        .bus                  (bus),
        .push_credit_stall    (stall),
        .credit_initial_push  (init_c),
        .credit_withhold_push (withhold),
        .push_sender_in_reset (in_reset),
        .credit_count_push    (count),
        .credit_available_push(avail),
        .credit_overflow      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        stall = 1'b0;
        init_c = 5'd17;
        withhold = 5'd0;
        bus.in_valid = 1'b0;
        bus.in_data = 8'd0;
        bus.push_credit = 1'b0;
        repeat (3) tick();

        check("rst_in_reset", 32'(in_reset), 32'd1);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_push_valid", 32'(bus.push_valid), 32'd0);
        check("rst_push_data", 32'(bus.push_data), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_overflow", 32'(ovf), 32'd0);

        rst_n = 1'b1;
        tick();
        check("init_in_reset", 32'(in_reset), 32'd1);
        check("init_count", 32'(count), 32'd0);
        tick();
        check("active_in_reset", 32'(in_reset), 32'd0);
        check("active_count", 32'(count), 32'd17);
        #1;
        check("active_in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 1; i <= 17; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(i);
            #1;
            check("stream_ready", 32'(bus.in_ready), 32'd1);
            tick();
            check("stream_pv", 32'(bus.push_valid), 32'd1);
            check("stream_pd", 32'(bus.push_data), 32'(i));
            check("stream_count", 32'(count), 32'(17 - i));
        end
        bus.in_data = 8'h12;
        #1;
        check("empty_ready", 32'(bus.in_ready), 32'd0);
        tick();
        check("held_pv", 32'(bus.push_valid), 32'd0);
        check("held_pd", 32'(bus.push_data), 32'h11);
        check("held_count", 32'(count), 32'd0);

        bus.in_valid = 1'b0;
        bus.push_credit = 1'b1;
        repeat (5) tick();
        check("return5_count", 32'(count), 32'd5);

        bus.in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.in_data = 8'(32 + k);
            tick();
            check("fireret_pv", 32'(bus.push_valid), 32'd1);
            check("fireret_pd", 32'(bus.push_data), 32'(32 + k));
            check("fireret_count", 32'(count), 32'd5);
        end
        bus.in_valid = 1'b0;
        bus.push_credit = 1'b0;
        tick();
        check("fireret_end_pv", 32'(bus.push_valid), 32'd0);
        check("fireret_end_count", 32'(count), 32'd5);

        bus.in_valid = 1'b1;
        bus.in_data = 8'h30;
        tick();
        bus.in_data = 8'h31;
        tick();
        check("to3_count", 32'(count), 32'd3);
        bus.in_valid = 1'b0;
        withhold = 5'd3;
        #1;
        check("wh_avail", 32'(avail), 32'd0);
        check("wh_ready", 32'(bus.in_ready), 32'd0);
        check("wh_count", 32'(count), 32'd3);
        bus.in_valid = 1'b1;
        bus.in_data = 8'h35;
        bus.push_credit = 1'b1;
        #1;
        check("wh_ready_valid", 32'(bus.in_ready), 32'd0);
        tick();
        check("wh_ret_count", 32'(count), 32'd4);
        check("wh_ret_pv", 32'(bus.push_valid), 32'd0);
        bus.push_credit = 1'b0;
        #1;
        check("wh_ret_avail", 32'(avail), 32'd1);
        check("wh_ret_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check("wh_one_pv", 32'(bus.push_valid), 32'd1);
        check("wh_one_pd", 32'(bus.push_data), 32'h35);
        check("wh_one_count", 32'(count), 32'd3);
        #1;
        check("wh_after_ready", 32'(bus.in_ready), 32'd0);
        check("wh_after_avail", 32'(avail), 32'd0);
        tick();
        check("wh_after_pv", 32'(bus.push_valid), 32'd0);

        bus.in_valid = 1'b0;
        withhold = 5'd0;
        bus.push_credit = 1'b1;
        repeat (14) tick();
        check("full_count", 32'(count), 32'd17);
        check("full_ovf", 32'(ovf), 32'd0);
        tick();
        check("ovf_count", 32'(count), 32'd17);
        check("ovf_set", 32'(ovf), 32'd1);
        bus.push_credit = 1'b0;
        repeat (3) tick();
        check("ovf_sticky", 32'(ovf), 32'd1);

        bus.in_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            bus.in_data = 8'(64 + k);
            tick();
        end
        check("mid_count10", 32'(count), 32'd10);
        bus.in_data = 8'h47;
        tick();
        bus.in_data = 8'h48;
        tick();
        check("mid_count8", 32'(count), 32'd8);
        stall = 1'b1;
        #1;
        check("stall_ready", 32'(bus.in_ready), 32'd0);
        check("stall_inflight_pv", 32'(bus.push_valid), 32'd1);
        check("stall_inflight_pd", 32'(bus.push_data), 32'h48);
        tick();
        check("stall_pv", 32'(bus.push_valid), 32'd0);
        check("stall_count", 32'(count), 32'd8);
        stall = 1'b0;
        bus.in_data = 8'h49;
        tick();
        check("resume_pv", 32'(bus.push_valid), 32'd1);
        check("resume_count", 32'(count), 32'd7);

        #3;
        rst_n = 1'b0;
        #1;
        check("kill_pv", 32'(bus.push_valid), 32'd0);
        check("kill_count", 32'(count), 32'd0);
        check("kill_in_reset", 32'(in_reset), 32'd1);
        check("kill_ready", 32'(bus.in_ready), 32'd0);
        check("kill_ovf", 32'(ovf), 32'd0);
        bus.in_valid = 1'b0;
        init_c = 5'd8;
        bus.push_credit = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("reinit_in_reset", 32'(in_reset), 32'd1);
        check("reinit_count", 32'(count), 32'd0);
        tick();
        check("reload_in_reset", 32'(in_reset), 32'd0);
        check("reload_count", 32'(count), 32'd8);
        check("reload_ovf", 32'(ovf), 32'd0);
        bus.push_credit = 1'b0;
        tick();
        check("reload_hold", 32'(count), 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
